kpn_fifo_channel: RTL and testbench



---
 rtl/kpn_fifo_channel.sv | 98 +++++++++
 tb/tb_kpn_fifo_channel.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/kpn_fifo_channel.sv
// rtl/kpn_fifo_channel.sv - bounded KPN token channel with reset-time token preload
// Optional macro KPN_FIFO_ERR_EN adds sticky overflow/underflow flag ports.
module kpn_fifo_channel #(
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    DEPTH       = 8,
  parameter int                    INIT_TOKENS = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr,
  input  logic [DATA_WIDTH-1:0]        entry_1,
  input  logic                         rd,
  output logic [DATA_WIDTH-1:0]        output_1,
  output logic                         out_valid,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef KPN_FIFO_ERR_EN
  ,
  output logic                         overflow,
  output logic                         underflow
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic                  rd_acc;
  logic                  wr_acc;

  // Wrap by explicit compare so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  // A full channel still takes a write when a read frees the oldest slot.
  assign rd_acc = rd & ~empty;
  assign wr_acc = wr & (~full | rd_acc);

  // Token storage: reset reloads the initial tokens, otherwise accepted writes land at wr_ptr.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i < INIT_TOKENS) mem[PW'(i)] <= INIT_VALUE;
      end
    end else if (wr_acc) begin
      mem[wr_ptr] <= entry_1;
    end
  end

  // Pointers and occupancy; simultaneous accepted read and write leave count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= PW'(INIT_TOKENS % DEPTH);
      count  <= CW'(INIT_TOKENS);
    end else begin
      if (rd_acc) rd_ptr <= next_ptr(rd_ptr);
      if (wr_acc) wr_ptr <= next_ptr(wr_ptr);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Registered read port: output_1 holds the last popped token, out_valid pulses per pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      output_1  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= rd_acc;
      if (rd_acc) output_1 <= mem[rd_ptr];
    end
  end

`ifdef KPN_FIFO_ERR_EN
  // Sticky protocol error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr && !wr_acc) overflow  <= 1'b1;
      if (rd && empty)   underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_kpn_fifo_channel.sv
// tb/tb_kpn_fifo_channel.sv - directed self-checking bench for kpn_fifo_channel
module tb_kpn_fifo_channel;

  localparam int DW = 16;
  localparam int DEPTH = 8;
  localparam int CW = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          wr, rd, rd1;
  logic [DW-1:0] entry_1;
  logic [DW-1:0] output_1, output_1b;
  logic          out_valid, out_validb;
  logic          full, fullb, empty, emptyb;
  logic [CW-1:0] count, countb;
`ifdef KPN_FIFO_ERR_EN
  logic          overflow, underflow, overflowb, underflowb;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  kpn_fifo_channel #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .INIT_TOKENS(0), .INIT_VALUE(16'd0)) dut (
    .clk(clk), .reset(reset), .wr(wr), .entry_1(entry_1), .rd(rd),
    .output_1(output_1), .out_valid(out_valid), .full(full), .empty(empty), .count(count)
`ifdef KPN_FIFO_ERR_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  kpn_fifo_channel #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .INIT_TOKENS(2), .INIT_VALUE(16'd1500)) dut_pre (
    .clk(clk), .reset(reset), .wr(1'b0), .entry_1(16'd0), .rd(rd1),
    .output_1(output_1b), .out_valid(out_validb), .full(fullb), .empty(emptyb), .count(countb)
`ifdef KPN_FIFO_ERR_EN
    , .overflow(overflowb), .underflow(underflowb)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] v);
    wr = 1'b1; entry_1 = v;
    tick();
    wr = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [DW-1:0] v);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, 32'(output_1), 32'(v));
  endtask

  initial begin
    reset = 1'b1; wr = 1'b0; rd = 1'b0; rd1 = 1'b0; entry_1 = '0;
    tick(); tick();
    reset = 1'b0;

    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(output_1), 32'd0);
    check("pre_count", 32'(countb), 32'd2);
    check("pre_empty", 32'(emptyb), 32'd0);
    check("pre_out", 32'(output_1b), 32'd0);

    // Preloaded channel: two tokens of 1500, then an empty read.
    rd1 = 1'b1;
    tick();
    check("pre1_out", 32'(output_1b), 32'd1500);
    check("pre1_valid", 32'(out_validb), 32'd1);
    check("pre1_count", 32'(countb), 32'd1);
    tick();
    check("pre2_out", 32'(output_1b), 32'd1500);
    check("pre2_valid", 32'(out_validb), 32'd1);
    check("pre2_count", 32'(countb), 32'd0);
    tick();
    rd1 = 1'b0;
    check("pre3_valid", 32'(out_validb), 32'd0);
    check("pre3_out", 32'(output_1b), 32'd1500);
    check("pre3_empty", 32'(emptyb), 32'd1);
    check("pre3_count", 32'(countb), 32'd0);
`ifdef KPN_FIFO_ERR_EN
    check("pre3_underflow", 32'(underflowb), 32'd1);
`endif

    // Fill and wrap.
    for (int i = 1; i <= 8; i++) push(DW'(i));
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd8);
    for (int i = 1; i <= 4; i++) pop_expect("wrap_a", DW'(i));
    check("wrap_count4", 32'(count), 32'd4);
    for (int i = 9; i <= 12; i++) push(DW'(i));
    check("wrap_full", 32'(full), 32'd1);
    for (int i = 5; i <= 12; i++) pop_expect("wrap_b", DW'(i));
    check("wrap_empty", 32'(empty), 32'd1);
    check("wrap_count0", 32'(count), 32'd0);

    // Write while full is dropped.
    for (int i = 1; i <= 8; i++) push(DW'(i));
    push(16'd99);
    check("ovf_count", 32'(count), 32'd8);
    check("ovf_full", 32'(full), 32'd1);
`ifdef KPN_FIFO_ERR_EN
    check("ovf_flag", 32'(overflow), 32'd1);
`endif
    for (int i = 1; i <= 8; i++) pop_expect("ovf_drain", DW'(i));
    check("ovf_empty", 32'(empty), 32'd1);

    // Simultaneous read and write on a full channel.
    for (int i = 1; i <= 8; i++) push(DW'(i));
    rd = 1'b1; wr = 1'b1; entry_1 = 16'd50;
    tick();
    rd = 1'b0; wr = 1'b0;
    check("sfull_out", 32'(output_1), 32'd1);
    check("sfull_valid", 32'(out_valid), 32'd1);
    check("sfull_count", 32'(count), 32'd8);
    for (int i = 2; i <= 8; i++) pop_expect("sfull_drain", DW'(i));
    pop_expect("sfull_last", 16'd50);
    check("sfull_empty", 32'(empty), 32'd1);

    // Simultaneous read and write on an empty channel.
    rd = 1'b1; wr = 1'b1; entry_1 = 16'd7;
    tick();
    rd = 1'b0; wr = 1'b0;
    check("sempty_valid", 32'(out_valid), 32'd0);
    check("sempty_count", 32'(count), 32'd1);
    check("sempty_hold", 32'(output_1), 32'd50);
`ifdef KPN_FIFO_ERR_EN
    check("sempty_underflow", 32'(underflow), 32'd1);
`endif
    pop_expect("sempty_read", 16'd7);

    // Reset mid-stream with a concurrent write.
    for (int i = 1; i <= 5; i++) push(DW'(20 + i));
    check("mid_count5", 32'(count), 32'd5);
    reset = 1'b1; wr = 1'b1; entry_1 = 16'd77;
    tick();
    reset = 1'b0; wr = 1'b0;
    check("mid_count", 32'(count), 32'd0);
    check("mid_empty", 32'(empty), 32'd1);
    check("mid_out", 32'(output_1), 32'd0);
    check("mid_valid", 32'(out_valid), 32'd0);
    check("mid_pre_count", 32'(countb), 32'd2);
`ifdef KPN_FIFO_ERR_EN
    check("mid_overflow", 32'(overflow), 32'd0);
    check("mid_underflow", 32'(underflow), 32'd0);
    check("mid_pre_underflow", 32'(underflowb), 32'd0);
`endif
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("mid_read_valid", 32'(out_valid), 32'd0);
    check("mid_read_out", 32'(output_1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
